rally_referee: RTL



---
 rtl/pong_pkg.sv | 22 ++
 rtl/btn_conditioner.sv | 53 +++++
 rtl/rally_referee.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the LED ping-pong game: referee FSM states, score defaults,
// LED vector width and the ball-position validity check.
package pong_pkg;

    localparam int unsigned LED_W         = 18;
    localparam int unsigned SCORE_W_DEF   = 4;
    localparam int unsigned WIN_SCORE_DEF = 7;
    localparam int unsigned BALL_MAX_W    = 64;

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        LEFT_END  = 2'd1,
        RIGHT_END = 2'd2,
        OVER      = 2'd3
    } ref_state_e;

    // True when exactly one bit is set; narrower vectors are zero-extended by the caller.
    function automatic logic is_one_hot(input logic [BALL_MAX_W-1:0] v);
        return (v != '0) && ((v & (v - BALL_MAX_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Paddle button conditioner: 2-flop synchronizer, stability debounce and a
// single-cycle pulse on each accepted press.
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
        end
    end

    // Accept a new level only after it has differed from the stable level for the full window.
    always_comb begin
        sync_d   = {sync_q[0], btn_i};
        stable_d = stable_q;
        cnt_d    = cnt_q;
        pulse_d  = 1'b0;
        if (sync_q[1] == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            stable_d = sync_q[1];
            pulse_d  = sync_q[1];
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/rally_referee.sv
// Rally referee for the LED ping-pong game: judges returns at each end, keeps scores
// and raises the winner's full flag. Optional return counter under RALLY_COUNT_EN.
module rally_referee
    import pong_pkg::*;
#(
    parameter int unsigned WIDTH           = LED_W,
    parameter int unsigned SCORE_W         = SCORE_W_DEF,
    parameter int unsigned WIN_SCORE       = WIN_SCORE_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   ball_pos,
    input  logic               btn_left,
    input  logic               btn_right,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic               point_left,
    output logic               point_right,
`ifdef RALLY_COUNT_EN
    output logic [7:0]         rally_count,
`endif
    output logic               left_full_flag,
    output logic               right_full_flag
);

    localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

    ref_state_e         state_q, state_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d;
    logic [SCORE_W-1:0] score_r_q, score_r_d;
    logic               point_l_q, point_l_d;
    logic               point_r_q, point_r_d;
    logic               flag_l_q, flag_l_d;
    logic               flag_r_q, flag_r_d;
    logic               hit_q, hit_d;
    logic [7:0]         rally_q, rally_d;

    logic               pulse_left, pulse_right;
    logic               ball_valid_c;
    logic               hit_left_c, hit_right_c;
    logic [SCORE_W-1:0] score_l_inc_c, score_r_inc_c;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_left (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn_left),
        .pulse_o (pulse_left)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_right (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn_right),
        .pulse_o (pulse_right)
    );

    assign ball_valid_c  = is_one_hot(BALL_MAX_W'(ball_pos));
    // A press landing in the exit cycle still counts, so fold it in before judging.
    assign hit_left_c    = hit_q | pulse_left;
    assign hit_right_c   = hit_q | pulse_right;
    assign score_l_inc_c = score_l_q + SCORE_W'(1);
    assign score_r_inc_c = score_r_q + SCORE_W'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= PLAY;
            score_l_q <= '0;
            score_r_q <= '0;
            point_l_q <= 1'b0;
            point_r_q <= 1'b0;
            flag_l_q  <= 1'b0;
            flag_r_q  <= 1'b0;
            hit_q     <= 1'b0;
            rally_q   <= '0;
        end else begin
            state_q   <= state_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            point_l_q <= point_l_d;
            point_r_q <= point_r_d;
            flag_l_q  <= flag_l_d;
            flag_r_q  <= flag_r_d;
            hit_q     <= hit_d;
            rally_q   <= rally_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        point_l_d = 1'b0;
        point_r_d = 1'b0;
        flag_l_d  = flag_l_q;
        flag_r_d  = flag_r_q;
        hit_d     = hit_q;
        rally_d   = rally_q;

        case (state_q)
            PLAY: begin
                if (ball_valid_c && ball_pos[WIDTH-1]) begin
                    state_d = LEFT_END;
                    hit_d   = 1'b0;
                end else if (ball_valid_c && ball_pos[0]) begin
                    state_d = RIGHT_END;
                    hit_d   = 1'b0;
                end
            end
            LEFT_END: begin
                hit_d = hit_left_c;
                if (ball_valid_c && !ball_pos[WIDTH-1]) begin
                    if (hit_left_c) begin
                        state_d = PLAY;
                        if (rally_q != 8'hFF) rally_d = rally_q + 8'd1;
                    end else begin
                        score_r_d = score_r_inc_c;
                        point_r_d = 1'b1;
                        rally_d   = '0;
                        if (score_r_inc_c == WIN_VAL) begin
                            state_d  = OVER;
                            flag_r_d = 1'b1;
                        end else begin
                            state_d = PLAY;
                        end
                    end
                end
            end
            RIGHT_END: begin
                hit_d = hit_right_c;
                if (ball_valid_c && !ball_pos[0]) begin
                    if (hit_right_c) begin
                        state_d = PLAY;
                        if (rally_q != 8'hFF) rally_d = rally_q + 8'd1;
                    end else begin
                        score_l_d = score_l_inc_c;
                        point_l_d = 1'b1;
                        rally_d   = '0;
                        if (score_l_inc_c == WIN_VAL) begin
                            state_d  = OVER;
                            flag_l_d = 1'b1;
                        end else begin
                            state_d = PLAY;
                        end
                    end
                end
            end
            OVER: begin
                state_d = OVER;
            end
            default: begin
                state_d = PLAY;
            end
        endcase
    end

    assign score_left      = score_l_q;
    assign score_right     = score_r_q;
    assign point_left      = point_l_q;
    assign point_right     = point_r_q;
    assign left_full_flag  = flag_l_q;
    assign right_full_flag = flag_r_q;

`ifdef RALLY_COUNT_EN
    assign rally_count = rally_q;
`else
    logic unused_rally_c;
    assign unused_rally_c = ^rally_q;
`endif

endmodule
